// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath: decodes the latched opcode
// into per-state datapath strobes and keeps a retired-instruction count plus a sticky illegal-opcode flag.
module multicycle_control #(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 32,
   parameter int WAIT_EN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    op_i,
   input  logic               mem_ready_i,
   output logic               pc_write_o,
   output logic               ir_write_o,
   output logic               iord_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic               mem_to_reg_o,
   output logic               reg_dst_o,
   output logic               reg_write_o,
   output logic               alu_src_a_o,
   output logic [1:0]         alu_src_b_o,
   output logic [1:0]         branch_o,
   output logic [1:0]         pc_source_o,
   output logic [ALUOP_W-1:0] aluop_o,
   output logic [3:0]         state_o,
   output logic               illegal_o,
   output logic               illegal_seen_o,
   output logic [CNT_W-1:0]   retired_o
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9
   } state_e;

   typedef enum logic [3:0] {
      OPC_R, OPC_SW, OPC_LW, OPC_ADDI, OPC_SLTI, OPC_ANDI,
      OPC_ORI, OPC_BEQ, OPC_BNE, OPC_JMP, OPC_ILL
   } opc_e;

   typedef struct packed {
      logic               pc_write;
      logic               iord;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               reg_dst;
      logic               reg_write;
      logic               alu_src_a;
      logic [1:0]         alu_src_b;
      logic [1:0]         branch;
      logic [1:0]         pc_source;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

   // Any set bit above [5:0] makes the opcode illegal regardless of the low field.
   function automatic opc_e classify(input logic [OP_W-1:0] op);
      if ((op >> 6) != '0) return OPC_ILL;
      case (op[5:0])
         6'd0:    return OPC_R;
         6'd1:    return OPC_SW;
         6'd2:    return OPC_LW;
         6'd3:    return OPC_ADDI;
         6'd4:    return OPC_SLTI;
         6'd5:    return OPC_ANDI;
         6'd6:    return OPC_ORI;
         6'd7:    return OPC_BEQ;
         6'd8:    return OPC_BNE;
         6'd9:    return OPC_JMP;
         default: return OPC_ILL;
      endcase
   endfunction

   function automatic ctrl_t moore_out(input state_e s, input opc_e c);
      ctrl_t o;
      o = '0;
      case (s)
         S_FETCH: begin
            o.mem_read  = 1'b1;
            o.alu_src_b = 2'b01;
            o.aluop     = ALUOP_W'(3'd1);
         end
         S_DECODE: begin
            o.alu_src_b = 2'b11;
            o.aluop     = ALUOP_W'(3'd1);
         end
         S_MEMADDR: begin
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'b10;
            o.aluop     = ALUOP_W'(3'd1);
         end
         S_MEMRD: begin
            o.mem_read = 1'b1;
            o.iord     = 1'b1;
         end
         S_MEMWB: begin
            o.reg_write  = 1'b1;
            o.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            o.mem_write = 1'b1;
            o.iord      = 1'b1;
         end
         S_EXEC: begin
            o.alu_src_a = 1'b1;
            o.alu_src_b = (c == OPC_R) ? 2'b00 : 2'b10;
            case (c)
               OPC_ADDI: o.aluop = ALUOP_W'(3'd1);
               OPC_SLTI: o.aluop = ALUOP_W'(3'd5);
               OPC_ANDI: o.aluop = ALUOP_W'(3'd3);
               OPC_ORI:  o.aluop = ALUOP_W'(3'd4);
               default:  o.aluop = ALUOP_W'(3'd0);
            endcase
         end
         S_ALUWB: begin
            o.reg_write = 1'b1;
            o.reg_dst   = (c == OPC_R);
         end
         S_BRANCH: begin
            o.alu_src_a = 1'b1;
            o.aluop     = ALUOP_W'(3'd2);
            o.pc_source = 2'b01;
            o.branch    = (c == OPC_BNE) ? 2'b10 : 2'b01;
         end
         S_JUMP: begin
            o.pc_write  = 1'b1;
            o.pc_source = 2'b10;
         end
         default: ;
      endcase
      return o;
   endfunction

   state_e            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              seen_q, seen_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic              ready;
   opc_e              opc_in, opc_q;

   assign ready  = (WAIT_EN == 0) ? 1'b1 : mem_ready_i;
   assign opc_in = classify(op_i);
   assign opc_q  = classify(op_q);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      retired_d = retired_q;
      seen_d    = seen_q;
      case (state_q)
         S_FETCH:   if (ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d = op_i;
            case (opc_in)
               OPC_R, OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: state_d = S_EXEC;
               OPC_LW, OPC_SW:                               state_d = S_MEMADDR;
               OPC_BEQ, OPC_BNE:                             state_d = S_BRANCH;
               OPC_JMP:                                      state_d = S_JUMP;
               default: begin
                  state_d = S_FETCH;
                  seen_d  = 1'b1;
               end
            endcase
         end
         S_MEMADDR: begin
            case (opc_q)
               OPC_LW:  state_d = S_MEMRD;
               OPC_SW:  state_d = S_MEMWR;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMRD:   if (ready) state_d = S_MEMWB;
         S_EXEC:    state_d = S_ALUWB;
         S_MEMWR: begin
            if (ready) begin
               state_d   = S_FETCH;
               retired_d = retired_q + CNT_W'(1);
            end
         end
         S_ALUWB, S_MEMWB, S_BRANCH, S_JUMP: begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_W'(1);
         end
         default:   state_d = S_FETCH;
      endcase
      ctrl_d = moore_out(state_d, classify(op_d));
   end

   // NOTE: Moore strobes are registered by decoding the next state, so they line up
   // with state_q without a combinational path from the state register to the pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         retired_q <= '0;
         seen_q    <= 1'b0;
         ctrl_q    <= moore_out(S_FETCH, OPC_R);
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         retired_q <= retired_d;
         seen_q    <= seen_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign pc_write_o     = ctrl_q.pc_write | ((state_q == S_FETCH) & ready);
   assign ir_write_o     = (state_q == S_FETCH) & ready;
   assign iord_o         = ctrl_q.iord;
   assign mem_read_o     = ctrl_q.mem_read;
   assign mem_write_o    = ctrl_q.mem_write;
   assign mem_to_reg_o   = ctrl_q.mem_to_reg;
   assign reg_dst_o      = ctrl_q.reg_dst;
   assign reg_write_o    = ctrl_q.reg_write;
   assign alu_src_a_o    = ctrl_q.alu_src_a;
   assign alu_src_b_o    = ctrl_q.alu_src_b;
   assign branch_o       = ctrl_q.branch;
   assign pc_source_o    = ctrl_q.pc_source;
   assign aluop_o        = ctrl_q.aluop;
   assign state_o        = state_q;
   assign illegal_o      = (state_q == S_DECODE) & (opc_in == OPC_ILL);
   assign illegal_seen_o = seen_q;
   assign retired_o      = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model expands each opcode
// into its expected state walk and strobe set; a second instance with a 2-bit counter checks wrap.
module tb_multicycle_control;

   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMRD = 4'd3,
                          MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7,
                          BRANCH = 4'd8, JUMP = 4'd9;
   localparam logic [5:0] OP_R = 6'd0, OP_SW = 6'd1, OP_LW = 6'd2, OP_ADDI = 6'd3,
                          OP_SLTI = 6'd4, OP_ANDI = 6'd5, OP_ORI = 6'd6, OP_BEQ = 6'd7,
                          OP_BNE = 6'd8, OP_JMP = 6'd9, OP_BAD = 6'h3F, OP_BAD2 = 6'h0A;

   logic       clk, rst, mem_ready_i;
   logic [5:0] op_i;

   logic       pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, mem_to_reg_o;
   logic       reg_dst_o, reg_write_o, alu_src_a_o, illegal_o, illegal_seen_o;
   logic [1:0] alu_src_b_o, branch_o, pc_source_o;
   logic [2:0] aluop_o;
   logic [3:0] state_o;
   logic [31:0] retired_o;

   logic       b_pc_write, b_ir_write, b_iord, b_mem_read, b_mem_write, b_mem_to_reg;
   logic       b_reg_dst, b_reg_write, b_alu_src_a, b_illegal, b_illegal_seen;
   logic [1:0] b_alu_src_b, b_branch, b_pc_source;
   logic [2:0] b_aluop;
   logic [3:0] b_state;
   logic [1:0] b_retired;

   multicycle_control dut (
      .clk(clk), .rst(rst), .op_i(op_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .iord_o(iord_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
      .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
      .alu_src_b_o(alu_src_b_o), .branch_o(branch_o), .pc_source_o(pc_source_o),
      .aluop_o(aluop_o), .state_o(state_o), .illegal_o(illegal_o),
      .illegal_seen_o(illegal_seen_o), .retired_o(retired_o)
   );

   multicycle_control #(.CNT_W(2)) dut_w2 (
      .clk(clk), .rst(rst), .op_i(op_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(b_pc_write), .ir_write_o(b_ir_write), .iord_o(b_iord),
      .mem_read_o(b_mem_read), .mem_write_o(b_mem_write), .mem_to_reg_o(b_mem_to_reg),
      .reg_dst_o(b_reg_dst), .reg_write_o(b_reg_write), .alu_src_a_o(b_alu_src_a),
      .alu_src_b_o(b_alu_src_b), .branch_o(b_branch), .pc_source_o(b_pc_source),
      .aluop_o(b_aluop), .state_o(b_state), .illegal_o(b_illegal),
      .illegal_seen_o(b_illegal_seen), .retired_o(b_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: what the current cycle must look like, set by the driver.
   logic [3:0]  exp_state;
   logic [5:0]  exp_op;
   logic        exp_ready;
   logic [31:0] m_retired;
   logic        m_seen;
   logic        chk_en = 1'b0;
   int          ncyc = 0;

   // Strobe set each state must present, straight from the control table.
   function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                           input logic rdy);
      logic pcw, irw, iord, mrd, mwr, m2r, rdst, rw, asa, ill;
      logic [1:0] asb, br, pcs;
      logic [2:0] aop;
      {pcw, irw, iord, mrd, mwr, m2r, rdst, rw, asa, ill} = '0;
      asb = 2'd0; br = 2'd0; pcs = 2'd0; aop = 3'd0;
      case (st)
         FETCH:   begin mrd = 1; asb = 2'b01; aop = 3'd1; pcw = rdy; irw = rdy; end
         DECODE:  begin asb = 2'b11; aop = 3'd1; ill = (op > OP_JMP); end
         MEMADDR: begin asa = 1; asb = 2'b10; aop = 3'd1; end
         MEMRD:   begin mrd = 1; iord = 1; end
         MEMWB:   begin rw = 1; m2r = 1; end
         MEMWR:   begin mwr = 1; iord = 1; end
         EXEC: begin
            asa = 1;
            asb = (op == OP_R) ? 2'b00 : 2'b10;
            if (op == OP_ADDI) aop = 3'd1;
            else if (op == OP_SLTI) aop = 3'd5;
            else if (op == OP_ANDI) aop = 3'd3;
            else if (op == OP_ORI) aop = 3'd4;
            else aop = 3'd0;
         end
         ALUWB:   begin rw = 1; rdst = (op == OP_R); end
         BRANCH:  begin asa = 1; aop = 3'd2; pcs = 2'b01; br = (op == OP_BEQ) ? 2'b01 : 2'b10; end
         JUMP:    begin pcw = 1; pcs = 2'b10; end
         default: ;
      endcase
      return {pcw, irw, iord, mrd, mwr, m2r, rdst, rw, asa, asb, br, pcs, aop, ill};
   endfunction

   logic [18:0] dut_vec, b_vec;
   assign dut_vec = {pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, mem_to_reg_o,
                     reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, branch_o, pc_source_o,
                     aluop_o, illegal_o};
   assign b_vec   = {b_pc_write, b_ir_write, b_iord, b_mem_read, b_mem_write, b_mem_to_reg,
                     b_reg_dst, b_reg_write, b_alu_src_a, b_alu_src_b, b_branch, b_pc_source,
                     b_aluop, b_illegal};

   always @(negedge clk) begin
      if (chk_en) begin
         check("state", 32'(state_o), 32'(exp_state));
         check("strobes", 32'(dut_vec), 32'(exp_vec(exp_state, exp_op, exp_ready)));
         check("retired", retired_o, m_retired);
         check("illegal_seen", 32'(illegal_seen_o), 32'(m_seen));
         check("w2_state", 32'(b_state), 32'(exp_state));
         check("w2_strobes", 32'(b_vec), 32'(exp_vec(exp_state, exp_op, exp_ready)));
         check("w2_retired", 32'(b_retired), 32'(m_retired[1:0]));
      end
   end

   task automatic cycle(input logic [3:0] st, input logic rdy, input logic [5:0] opv,
                        input logic [5:0] iop);
      op_i        = opv;
      mem_ready_i = rdy;
      exp_state   = st;
      exp_op      = iop;
      exp_ready   = rdy;
      chk_en      = 1'b1;
      @(posedge clk);
      #1;
      ncyc++;
   endtask

   function automatic logic noise();
      return 1'($urandom_range(0, 1));
   endfunction

   // Walks one instruction; op_i is scrambled after DECODE so only the latched opcode matters.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int exp_cyc);
      int start;
      logic [5:0] junk;
      start = ncyc;
      junk  = op ^ 6'h15;
      for (int i = 0; i < fw; i++) cycle(FETCH, 1'b0, op, op);
      cycle(FETCH, 1'b1, op, op);
      cycle(DECODE, noise(), op, op);
      if (op > OP_JMP) begin
         m_seen = 1'b1;
      end else begin
         case (op)
            OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
               cycle(EXEC, noise(), junk, op);
               cycle(ALUWB, noise(), junk, op);
            end
            OP_LW: begin
               cycle(MEMADDR, noise(), junk, op);
               for (int i = 0; i < mw; i++) cycle(MEMRD, 1'b0, junk, op);
               cycle(MEMRD, 1'b1, junk, op);
               cycle(MEMWB, noise(), junk, op);
            end
            OP_SW: begin
               cycle(MEMADDR, noise(), junk, op);
               for (int i = 0; i < mw; i++) cycle(MEMWR, 1'b0, junk, op);
               cycle(MEMWR, 1'b1, junk, op);
            end
            OP_BEQ, OP_BNE: cycle(BRANCH, noise(), junk, op);
            default:        cycle(JUMP, noise(), junk, op);
         endcase
         m_retired = m_retired + 32'd1;
      end
      check("cycle_count", 32'(ncyc - start), 32'(exp_cyc));
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      op_i        = 6'd0;
      mem_ready_i = 1'b1;
      @(posedge clk);
      #1;
      m_retired = 32'd0;
      m_seen    = 1'b0;
      cycle(FETCH, 1'b1, 6'd0, 6'd0);
      cycle(FETCH, 1'b0, 6'd0, 6'd0);
      rst = 1'b0;
   endtask

   int exp_w2 [5] = '{1, 2, 3, 0, 1};

   initial begin
      rst = 1'b1;
      op_i = 6'd0;
      mem_ready_i = 1'b1;
      do_reset();
      check("reset_state", 32'(state_o), 32'd0);
      check("reset_retired", retired_o, 32'd0);

      run_instr(OP_R, 0, 0, 4);
      check("retired_after_r", retired_o, 32'd1);
      run_instr(OP_LW, 0, 2, 7);
      run_instr(OP_SW, 0, 0, 4);
      run_instr(OP_SW, 1, 1, 6);
      run_instr(OP_ADDI, 0, 0, 4);
      run_instr(OP_SLTI, 0, 0, 4);
      run_instr(OP_ANDI, 0, 0, 4);
      run_instr(OP_ORI, 2, 0, 6);
      run_instr(OP_BEQ, 0, 0, 3);
      run_instr(OP_BNE, 0, 0, 3);
      run_instr(OP_JMP, 0, 0, 3);
      check("retired_before_illegal", retired_o, 32'd11);
      run_instr(OP_BAD, 0, 0, 2);
      check("illegal_seen_set", 32'(illegal_seen_o), 32'd1);
      check("retired_after_illegal", retired_o, 32'd11);
      run_instr(OP_BAD2, 0, 0, 2);
      run_instr(OP_LW, 1, 0, 6);
      check("illegal_seen_sticky", 32'(illegal_seen_o), 32'd1);

      // Reset lands while a store is stalled waiting for memory.
      cycle(FETCH, 1'b1, OP_SW, OP_SW);
      cycle(DECODE, 1'b1, OP_SW, OP_SW);
      cycle(MEMADDR, 1'b1, 6'h2A, OP_SW);
      cycle(MEMWR, 1'b0, 6'h2A, OP_SW);
      rst = 1'b1;
      cycle(MEMWR, 1'b0, 6'h2A, OP_SW);
      rst = 1'b0;
      m_retired = 32'd0;
      m_seen    = 1'b0;
      check("rst_wait_state", 32'(state_o), 32'd0);
      check("rst_wait_mem_write", 32'(mem_write_o), 32'd0);
      check("rst_wait_retired", retired_o, 32'd0);
      check("rst_wait_seen", 32'(illegal_seen_o), 32'd0);

      for (int i = 0; i < 5; i++) begin
         run_instr(OP_JMP, 0, 0, 3);
         check("w2_wrap", 32'(b_retired), 32'(exp_w2[i]));
      end
      check("retired_full_width", retired_o, 32'd5);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
